// File: rtl/sprite_multi_pkg.sv
// Shared register map, field positions and per-sprite register struct.
package sprite_multi_pkg;

  localparam int OFFSET_BITS     = 16;
  localparam int SCALE_BITS_BITS = 4;
  localparam int PIPE_LATENCY    = 7;

  localparam logic [1:0] REG_X     = 2'd0;
  localparam logic [1:0] REG_Y     = 2'd1;
  localparam logic [1:0] REG_SCALE = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_KEY_EN  = 1;
  localparam int CTRL_KEY_LSB = 8;

  // ctrl is kept raw; each channel slices the key at its own BPP
  typedef struct packed {
    logic signed [OFFSET_BITS-1:0]   x;
    logic signed [OFFSET_BITS-1:0]   y;
    logic [SCALE_BITS_BITS-1:0]      scale;
    logic [31:0]                     ctrl;
  } sprite_regs_t;

  localparam sprite_regs_t REGS_RESET = '{x: '0, y: '0, scale: 4'd8, ctrl: '0};

endpackage

// File: rtl/dual_clk_ram.sv
// Simple dual-port RAM; read returns old data on same-address write.
module dual_clk_ram #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          wr_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_clk,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [2**AW];

  // write port
  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // registered read port
  always_ff @(posedge rd_clk) begin
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sprite_channel.sv
// One sprite: offset, scale, bitmap fetch and key test (stages d1..d5).
module sprite_channel import sprite_multi_pkg::*; #(
  parameter int SPRITE_SIZE_BITS = 6,
  parameter int BPP              = 8,
  parameter int SCALE_DIV_BITS   = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [OFFSET_BITS-1:0]          count_h,
  input  logic [OFFSET_BITS-1:0]          count_v,
  input  sprite_regs_t                    cfg,
  input  logic                            bm_we,
  input  logic [2*SPRITE_SIZE_BITS-1:0]   bm_addr,
  input  logic [BPP-1:0]                  bm_din,
  output logic [BPP-1:0]                  pix,
  output logic                            opaque
);
  localparam int SSB = SPRITE_SIZE_BITS;

  sprite_regs_t                 c1, c2, c3, c4;
  logic signed [OFFSET_BITS-1:0] dx0, dy0;
  logic signed [31:0]           dx_ext, dy_ext, dx_sh, dy_sh;
  logic [SSB-1:0]               dx1, dy1;
  logic                         inside2, inside3, inside4;
  logic [2*SSB-1:0]             raddr3;
  logic [BPP-1:0]               data4, key4;

  // widen then scale; the arithmetic right shift keeps negative offsets negative
  always_comb begin
    dx_ext = {{(32-OFFSET_BITS){dx0[OFFSET_BITS-1]}}, dx0};
    dy_ext = {{(32-OFFSET_BITS){dy0[OFFSET_BITS-1]}}, dy0};
    dx_sh  = (dx_ext <<< c1.scale) >>> SCALE_DIV_BITS;
    dy_sh  = (dy_ext <<< c1.scale) >>> SCALE_DIV_BITS;
  end

  assign key4 = c4.ctrl[CTRL_KEY_LSB +: BPP];

  // d1..d3, d5 pipeline; each stage carries the regs it was launched with
  always_ff @(posedge clk) begin
    if (!reset) begin
      c1 <= '0; c2 <= '0; c3 <= '0; c4 <= '0;
      dx0 <= '0; dy0 <= '0;
      dx1 <= '0; dy1 <= '0; inside2 <= 1'b0;
      raddr3 <= '0; inside3 <= 1'b0; inside4 <= 1'b0;
      pix <= '0; opaque <= 1'b0;
    end else begin
      c1 <= cfg; c2 <= c1; c3 <= c2; c4 <= c3;
      dx0 <= $signed(count_h) - cfg.x;
      dy0 <= $signed(count_v) - cfg.y;
      dx1 <= dx_sh[SSB-1:0];
      dy1 <= dy_sh[SSB-1:0];
      inside2 <= (dx_sh[31:SSB] == '0) && (dy_sh[31:SSB] == '0);
      raddr3 <= {dy1, dx1};
      inside3 <= inside2;
      inside4 <= inside3;
      opaque <= c4.ctrl[CTRL_EN] & inside4 & !(c4.ctrl[CTRL_KEY_EN] && (data4 == key4));
      pix <= data4;
    end
  end

  dual_clk_ram #(.AW(2*SSB), .DW(BPP)) u_ram (
    .wr_clk (clk),
    .wr_en  (bm_we),
    .wr_addr(bm_addr),
    .wr_data(bm_din),
    .rd_clk (clk),
    .rd_addr(raddr3),
    .rd_data(data4)
  );

  logic unused_cfg;
  assign unused_cfg = ^{c1.x, c1.y, c4.x, c4.y, c4.scale, c4.ctrl};
endmodule

// File: rtl/sprite_multi.sv
// Multi-sprite engine: shadowed regs, per-sprite channels, priority mux, collision.
module sprite_multi import sprite_multi_pkg::*; #(
  parameter int NUM_SPRITES      = 4,
  parameter int SPRITE_SIZE_BITS = 6,
  parameter int BPP              = 8,
  parameter int SCALE_DIV_BITS   = 8
) (
  input  logic           clk,
  input  logic           reset,
  output logic [31:0]    bitmap_length,
  input  logic [31:0]    bitmap_address,
  input  logic [BPP-1:0] bitmap_din,
  input  logic           bitmap_we,
  input  logic [7:0]     reg_address,
  input  logic [31:0]    reg_din,
  input  logic           reg_we,
  input  logic [31:0]    count_h,
  input  logic [31:0]    count_v,
  output logic [BPP-1:0] color,
  output logic           collision
);
  localparam int PIX_BITS = 2*SPRITE_SIZE_BITS;
  localparam int SEL_BITS = 32 - PIX_BITS;
  localparam int STAGES   = 5;  // last per-sprite stage

  sprite_regs_t [NUM_SPRITES-1:0]          staging, active, cur;
  logic [NUM_SPRITES-1:0][BPP-1:0]         pix;
  logic [NUM_SPRITES-1:0]                  opaque;
  logic [STAGES:1]                         vld_pipe;
  logic [5:0]                              wr_sprite;
  logic [SEL_BITS-1:0]                     bm_sprite;
  logic                                    frame_start, any_opq, multi, hit, coll_acc;
  logic [BPP-1:0]                          win_pix, comp_pix;

  assign bitmap_length = 32'(NUM_SPRITES) << PIX_BITS;
  assign frame_start   = (count_v == '0) && (count_h == '0);
  assign wr_sprite     = reg_address[7:2];
  assign bm_sprite     = bitmap_address[31:PIX_BITS];
  // the frame_start pixel itself already sees next frame's regs
  assign cur           = frame_start ? staging : active;

  // CPU writes land in staging; active copies staging (pre-write) at frame start
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        staging[i] <= REGS_RESET;
        active[i]  <= REGS_RESET;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (reg_we && wr_sprite == 6'(i)) begin
          case (reg_address[1:0])
            REG_X:     staging[i].x     <= reg_din[OFFSET_BITS-1:0];
            REG_Y:     staging[i].y     <= reg_din[OFFSET_BITS-1:0];
            REG_SCALE: staging[i].scale <= reg_din[SCALE_BITS_BITS-1:0];
            default:   staging[i].ctrl  <= reg_din;
          endcase
        end
      end
      if (frame_start) active <= staging;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
    sprite_channel #(
      .SPRITE_SIZE_BITS(SPRITE_SIZE_BITS),
      .BPP             (BPP),
      .SCALE_DIV_BITS  (SCALE_DIV_BITS)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .count_h(count_h[OFFSET_BITS-1:0]),
      .count_v(count_v[OFFSET_BITS-1:0]),
      .cfg    (cur[g]),
      .bm_we  (bitmap_we && (bm_sprite == SEL_BITS'(g))),
      .bm_addr(bitmap_address[PIX_BITS-1:0]),
      .bm_din (bitmap_din),
      .pix    (pix[g]),
      .opaque (opaque[g])
    );
  end

  // fixed priority: lowest opaque index wins, a second opaque one is a hit
  always_comb begin
    win_pix = '0;
    multi   = 1'b0;
    any_opq = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (opaque[i]) begin
        if (any_opq) multi = 1'b1;
        else         win_pix = pix[i];
        any_opq = 1'b1;
      end
    end
  end

  assign hit = multi & vld_pipe[STAGES];

  // d6 composite, d7 output register, valid shift register
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      comp_pix <= '0;
      color    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], 1'b1};
      comp_pix <= vld_pipe[STAGES] ? win_pix : '0;
      color    <= comp_pix;
    end
  end

  // per-frame collision: publish accumulated hits (incl. this cycle) and restart
  always_ff @(posedge clk) begin
    if (!reset) begin
      coll_acc  <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= coll_acc | hit;
      coll_acc  <= 1'b0;
    end else if (hit) begin
      coll_acc <= 1'b1;
    end
  end
endmodule
